addbit_pipe: RTL and testbench
==============================

Name: addbit_pipe

Overview:
Parametrised successor to the gate/RTL 1-bit adder: a WIDTH-bit pipelined ripple-carry adder with carry-in, carry-out and signed-overflow flag. It is built as a chain of STAGE_BITS-wide slices with one register stage per slice, and operand slices are skewed so each slice adds on the cycle its carry arrives. A valid/ready handshake on both sides, with full-pipeline stall, lets it sit between streaming producers and consumers in the PLI test designs.

Parameters:
WIDTH, 8, operand and sum width in bits (>=1)
STAGE_BITS, 4, bits added per pipeline stage (1..WIDTH); NSTAGES = ceil(WIDTH/STAGE_BITS); last slice may be narrower

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operands a, b, ci valid this cycle
in_ready  output  1  adder accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
ci  input  1  carry-in
out_valid  output  1  sum, co, ovf valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  (a+b+ci) mod 2^WIDTH
co  output  1  unsigned carry-out of MSB
ovf  output  1  signed two's-complement overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Clock and reset: one clock, clk; synchronous, active-high reset rst, sampled on the rising edge of clk.
- Reset: all stage valid bits clear; out_valid=0, sum=0, co=0, ovf=0; in_ready=1 in the cycle after reset deasserts. Reset mid-operation discards all in-flight results with no partial output.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall, a combinational function of registered out_valid and out_ready. When stall=1 no pipeline register changes and outputs hold stable.
- Accept: a transfer occurs when in_valid & in_ready. A stage valid bit advances when not stalled; bubbles propagate as valid=0 and do not collapse.
- Stage k (0-based) adds bits [k*STAGE_BITS +: width_k] of a and b plus a carry. The carry is ci for k=0 and the registered carry of stage k-1 otherwise. Upper operand slices and lower sum slices are delay-aligned in skew registers.
- Latency: exactly NSTAGES cycles from accept to out_valid, absent stall. Throughput is 1 result/cycle when out_ready=1.
- ovf is computed in the final stage from the MSB carry-in and carry-out. WIDTH=1 is legal: ovf = ci_into_bit0 ^ co.
- Ordering: results emerge in acceptance order; none are dropped or duplicated under any out_ready pattern.
- Simultaneous accept with output drain in the same cycle is allowed and sustains full rate.
- Inputs are don't-care when in_valid=0, and also when in_ready=0 (not sampled).
- Synthesizable: no latches, no delays, no system tasks outside ifdef'd assertions.

Optional Feature:
ADDBIT_PIPE_SAT_EN
- Defined: the final stage applies signed saturation. If ovf=1, sum becomes 0111…1 when both operand MSBs were 0, and 1000…0 when both were 1. co and ovf still report the raw, unsaturated result.
- Undefined: sum is always the wrapped modulo result, with no extra logic. Latency is identical in both modes.

Test Plan:
All cases use WIDTH=8, STAGE_BITS=4 (latency 2) unless stated.
- Reset: hold rst 3 cycles while in_valid=1 -> out_valid=0, sum=0, co=0, ovf=0 throughout; in_ready=1 after release.
- Single op: a=8'h03, b=8'h01, ci=1 -> 2 cycles later out_valid=1, sum=8'h05, co=0, ovf=0.
- Cross-stage carry: a=8'h0F, b=8'h01, ci=0 -> sum=8'h10. Then a=8'hFF, b=8'h01 -> sum=8'h00, co=1, ovf=0. Then a=8'h7F, b=8'h01 -> sum=8'h80, ovf=1 (8'h7F with ADDBIT_PIPE_SAT_EN), co=0.
- Back-to-back stream: inputs 0..31 with b=i, out_ready=1 -> 32 consecutive results sum=2i mod 256, in order, no gaps.
- Backpressure: stream while out_ready toggles with random 50% duty -> in_ready=0 exactly when out_valid & ~out_ready; outputs stable while stalled; scoreboard matches all 100 results.
- Reset mid-flight: rst asserted with 2 results in flight -> next cycle out_valid=0; first post-reset result appears exactly 2 cycles after its accept. Sweep WIDTH=1/STAGE_BITS=1 and WIDTH=13/STAGE_BITS=4 (NSTAGES=4) with exhaustive or 10k random vectors against a+b+ci.

Source files
------------

// File: rtl/addbit_pipe_if.sv
// addbit_pipe_if: valid/ready operand and result bundle for addbit_pipe.
// The adder connects to the slave modport and the producer/consumer side to the master modport.
interface addbit_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;
    modport master (
        output in_valid, a, b, ci, out_ready,
        input  in_ready, out_valid, sum, co, ovf
    );
    modport slave (
        input  in_valid, a, b, ci, out_ready,
        output in_ready, out_valid, sum, co, ovf
    );
endinterface

// File: rtl/addbit_pipe.sv
// addbit_pipe: WIDTH-bit pipelined ripple-carry adder, one register stage per STAGE_BITS slice.
// Define ADDBIT_PIPE_SAT_EN to saturate the final sum on signed overflow (co/ovf stay raw).
module addbit_pipe #(
    parameter int WIDTH      = 8,
    parameter int STAGE_BITS = 4
) (
    input logic          clk,
    input logic          rst,
    addbit_pipe_if.slave bus
);
    localparam int NSTAGES = (WIDTH + STAGE_BITS - 1) / STAGE_BITS;
    logic [WIDTH-1:0] a_s [NSTAGES];
    logic [WIDTH-1:0] b_s [NSTAGES];
    logic [WIDTH-1:0] s_s [NSTAGES];
    logic             c_s [NSTAGES];
    logic             o_s [NSTAGES];
    logic             v_s [NSTAGES];
    logic             stall;
    assign stall         = v_s[NSTAGES-1] & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = v_s[NSTAGES-1];
    assign bus.sum       = s_s[NSTAGES-1];
    assign bus.co        = c_s[NSTAGES-1];
    assign bus.ovf       = o_s[NSTAGES-1];
    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        localparam int LO = k * STAGE_BITS;
        localparam int W  = (WIDTH - LO < STAGE_BITS) ? WIDTH - LO : STAGE_BITS;
`ifdef ADDBIT_PIPE_SAT_EN
        localparam bit               LAST = (k == NSTAGES - 1);
        localparam logic [WIDTH-1:0] MSB  = WIDTH'(1) << (WIDTH - 1);
`endif
        logic [WIDTH-1:0] a_x, b_x, s_x, s_d, a_q, b_q, s_q;
        logic             c_x, v_x, o_d, c_q, o_q, v_q;
        logic [W:0]       r;
        if (k == 0) begin : g_head
            assign a_x = bus.a;
            assign b_x = bus.b;
            assign s_x = '0;
            assign c_x = bus.ci;
            assign v_x = bus.in_valid;
        end else begin : g_link
            assign a_x = a_s[k-1];
            assign b_x = b_s[k-1];
            assign s_x = s_s[k-1];
            assign c_x = c_s[k-1];
            assign v_x = v_s[k-1];
        end
        // operands ride along in full so the last stage still sees both MSBs
        always_comb begin
            r = {1'b0, a_x[LO +: W]} + {1'b0, b_x[LO +: W]} + {{W{1'b0}}, c_x};
            s_d = s_x;
            s_d[LO +: W] = r[W-1:0];
            o_d = a_x[WIDTH-1] ^ b_x[WIDTH-1] ^ s_d[WIDTH-1] ^ r[W];
`ifdef ADDBIT_PIPE_SAT_EN
            s_d = (LAST && o_d) ? ({WIDTH{s_d[WIDTH-1]}} ^ MSB) : s_d;
`endif
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                o_q <= 1'b0;
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
            end else if (!stall) begin
                v_q <= v_x;
                c_q <= r[W];
                o_q <= o_d;
                a_q <= a_x;
                b_q <= b_x;
                s_q <= s_d;
            end
        end
        assign a_s[k] = a_q;
        assign b_s[k] = b_q;
        assign s_s[k] = s_q;
        assign c_s[k] = c_q;
        assign o_s[k] = o_q;
        assign v_s[k] = v_q;
    end
endmodule

// File: tb/tb_addbit_pipe.sv
// tb_addbit_pipe: directed vector table for the 8-bit adder plus stream, backpressure,
// mid-flight reset and WIDTH=1 / WIDTH=13 sweeps against an arithmetic reference.
module tb_addbit_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
`ifdef ADDBIT_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    addbit_pipe_if #(.WIDTH(8))  bus8 ();
    addbit_pipe_if #(.WIDTH(1))  bus1 ();
    addbit_pipe_if #(.WIDTH(13)) bus13 ();
    addbit_pipe #(.WIDTH(8),  .STAGE_BITS(4)) dut   (.clk(clk), .rst(rst), .bus(bus8));
    addbit_pipe #(.WIDTH(1),  .STAGE_BITS(1)) dut1  (.clk(clk), .rst(rst), .bus(bus1));
    addbit_pipe #(.WIDTH(13), .STAGE_BITS(4)) dut13 (.clk(clk), .rst(rst), .bus(bus13));
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] sum;
        logic       co;
        logic       ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // returns {1'b0, ovf, co, sum[12:0]} for a w-bit add, sign-rule overflow
    function automatic logic [15:0] model(input int w, input logic [12:0] a, input logic [12:0] b, input logic ci);
        int unsigned mask, t, s;
        logic am, bm, sm, co, ov;
        mask = (32'd1 << w) - 1;
        t  = (a & mask) + (b & mask) + {31'd0, ci};
        s  = t & mask;
        co = ((t >> w) & 1) != 0;
        am = ((a >> (w - 1)) & 1) != 0;
        bm = ((b >> (w - 1)) & 1) != 0;
        sm = ((s >> (w - 1)) & 1) != 0;
        ov = (am == bm) && (sm != am);
        if (SAT && ov) s = am ? (mask ^ (mask >> 1)) : (mask >> 1);
        return {1'b0, ov, co, s[12:0]};
    endfunction

    initial begin
        vec_t        tbl [7];
        logic [15:0] sb [$];
        logic [15:0] e;
        logic [10:0] held;
        logic        stalled;
        int          acc, got, cyc;
        tbl[0] = '{8'h03, 8'h01, 1'b1, 8'h05, 1'b0, 1'b0};
        tbl[1] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        tbl[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[3] = '{8'h7F, 8'h01, 1'b0, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1};
        tbl[4] = '{8'h80, 8'h80, 1'b0, SAT ? 8'h80 : 8'h00, 1'b1, 1'b1};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[6] = '{8'h40, 8'h3F, 1'b1, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1};
        bus8.in_valid = 1'b1;  bus8.a = 8'hFF;  bus8.b = 8'hFF;  bus8.ci = 1'b1;  bus8.out_ready = 1'b1;
        bus1.in_valid = 1'b0;  bus1.a = '0;     bus1.b = '0;     bus1.ci = 1'b0;  bus1.out_ready = 1'b1;
        bus13.in_valid = 1'b0; bus13.a = '0;    bus13.b = '0;    bus13.ci = 1'b0; bus13.out_ready = 1'b1;

        // reset held with in_valid asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_out_valid", bus8.out_valid, 0);
            check("rst_sum", bus8.sum, 0);
            check("rst_co_ovf", {bus8.co, bus8.ovf}, 0);
        end
        rst = 1'b0;
        bus8.in_valid = 1'b0;
        #1;
        check("rst_in_ready", bus8.in_ready, 1);
        tick();
        check("post_rst_idle", bus8.out_valid, 0);

        // directed table, one op at a time with latency check
        for (int i = 0; i < 7; i++) begin
            bus8.a = tbl[i].a; bus8.b = tbl[i].b; bus8.ci = tbl[i].ci; bus8.in_valid = 1'b1;
            tick();
            bus8.in_valid = 1'b0;
            check($sformatf("vec%0d_early", i), bus8.out_valid, 0);
            tick();
            check($sformatf("vec%0d_valid", i), bus8.out_valid, 1);
            check($sformatf("vec%0d_sum", i), bus8.sum, tbl[i].sum);
            check($sformatf("vec%0d_co", i), bus8.co, tbl[i].co);
            check($sformatf("vec%0d_ovf", i), bus8.ovf, tbl[i].ovf);
            tick();
            check($sformatf("vec%0d_drain", i), bus8.out_valid, 0);
        end

        // back-to-back stream, exact cadence
        for (int c = 0; c < 34; c++) begin
            bus8.in_valid = (c < 32); bus8.a = 8'(c); bus8.b = 8'(c); bus8.ci = 1'b0;
            tick();
            check("stream_valid", bus8.out_valid, (c >= 1 && c <= 32));
            if (c >= 1 && c <= 32) check("stream_sum", bus8.sum, 8'(2 * (c - 1)));
        end

        // random backpressure with scoreboard
        acc = 0; got = 0; cyc = 0;
        while (got < 100 && cyc < 2000) begin
            bus8.out_ready = 1'($urandom_range(0, 1));
            bus8.in_valid  = (acc < 100) && ($urandom_range(0, 3) != 0);
            bus8.a  = 8'($urandom);
            bus8.b  = 8'($urandom);
            bus8.ci = 1'($urandom_range(0, 1));
            #1;
            check("bp_in_ready", bus8.in_ready, !(bus8.out_valid && !bus8.out_ready));
            if (bus8.in_valid && bus8.in_ready) begin
                sb.push_back(model(8, {5'd0, bus8.a}, {5'd0, bus8.b}, bus8.ci));
                acc++;
            end
            if (bus8.out_valid && bus8.out_ready) begin
                if (sb.size() == 0) check("bp_extra_result", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("bp_result", {bus8.ovf, bus8.co, bus8.sum}, {e[14], e[13], e[7:0]});
                end
                got++;
            end
            stalled = bus8.out_valid && !bus8.out_ready;
            held = {bus8.out_valid, bus8.co, bus8.ovf, bus8.sum};
            tick();
            cyc++;
            if (stalled) check("bp_hold", {bus8.out_valid, bus8.co, bus8.ovf, bus8.sum}, held);
        end
        check("bp_count", got, 100);
        check("bp_leftover", sb.size(), 0);
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        tick();

        // reset with two results in flight
        bus8.a = 8'h11; bus8.b = 8'h22; bus8.ci = 1'b0; bus8.in_valid = 1'b1;
        tick();
        bus8.a = 8'h33; bus8.b = 8'h44;
        tick();
        bus8.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", bus8.out_valid, 0);
        check("midrst_sum", bus8.sum, 0);
        tick();
        check("midrst_no_leak", bus8.out_valid, 0);
        bus8.a = 8'h21; bus8.b = 8'h12; bus8.ci = 1'b1; bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        check("midrst_early", bus8.out_valid, 0);
        tick();
        check("midrst_first_valid", bus8.out_valid, 1);
        check("midrst_first_sum", bus8.sum, 8'h34);
        tick();
        check("midrst_drain", bus8.out_valid, 0);

        // WIDTH=1, STAGE_BITS=1 exhaustive (latency 1)
        for (int c = 0; c < 9; c++) begin
            bus1.in_valid = (c < 8); bus1.a = c[0]; bus1.b = c[1]; bus1.ci = c[2];
            tick();
            check("w1_valid", bus1.out_valid, (c < 8));
            if (c < 8) begin
                e = model(1, {12'd0, c[0]}, {12'd0, c[1]}, c[2]);
                check($sformatf("w1_vec%0d", c), {bus1.ovf, bus1.co, bus1.sum}, {e[14], e[13], e[0]});
            end
        end

        // WIDTH=13, STAGE_BITS=4 random stream (latency 4)
        sb.delete();
        got = 0;
        for (int c = 0; c < 303; c++) begin
            bus13.in_valid = (c < 300);
            bus13.a  = 13'($urandom);
            bus13.b  = 13'($urandom);
            bus13.ci = 1'($urandom_range(0, 1));
            if (c < 300) sb.push_back(model(13, bus13.a, bus13.b, bus13.ci));
            tick();
            check("w13_valid", bus13.out_valid, (c >= 3));
            if (bus13.out_valid) begin
                if (sb.size() == 0) check("w13_extra_result", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("w13_result", {bus13.ovf, bus13.co, bus13.sum}, e[14:0]);
                end
                got++;
            end
        end
        check("w13_count", got, 300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
